// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM states and word-assembly constants for the instruction loader
package imem_loader_pkg;
  typedef enum logic [2:0] {ST_ADDR, ST_CNT, ST_DATA, ST_DONE, ST_ERR} state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [31:0] ADDR_INC = 32'd4;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte stream in, core fill port and load status out
// master: host/consumer side (drives RxByte/RxVal); slave: the loader
interface imem_loader_if;
  logic [7:0] RxByte;
  logic RxVal;
  logic RxReady;
  logic [31:0] IntrAddr_FL0;
  logic [31:0] IntrFill_FL0;
  logic FillVal_FL0;
  logic CoreReset;
  logic LoadDone;
  logic LoadErr;
  modport master(output RxByte, RxVal, input RxReady, IntrAddr_FL0, IntrFill_FL0, FillVal_FL0, CoreReset, LoadDone, LoadErr);
  modport slave(input RxByte, RxVal, output RxReady, IntrAddr_FL0, IntrFill_FL0, FillVal_FL0, CoreReset, LoadDone, LoadErr);
endinterface

// File: rtl/imem_loader_word_pack.sv
// imem_loader_word_pack: assembles big-endian 32-bit words from a byte stream
// in: clk, reset, clear (drop partial word), byteIn/byteVal; out: word, wordVal (combinational, with 4th byte)
module imem_loader_word_pack
  import imem_loader_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic [7:0] byteIn,
  input  logic byteVal,
  output logic [31:0] word,
  output logic wordVal
);
  logic [1:0] idx;
  logic [23:0] sr;
  assign word = {sr, byteIn};
  assign wordVal = byteVal && idx == 2'(BYTES_PER_WORD - 1);
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      idx <= '0;
      sr <= '0;
    end else if (byteVal) begin
      idx <= idx + 2'd1;
      sr <= {sr[15:0], byteIn};
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads an address/count/data byte image into the core instruction store
// in: clk, reset, bus.RxByte/RxVal; out: bus.RxReady, fill port (IntrAddr_FL0/IntrFill_FL0/FillVal_FL0),
// CoreReset, LoadDone pulse, LoadErr
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MAX_WORDS = 1024,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  imem_loader_if.slave bus
);
  state_t st, stNext;
  logic byteVal, wordVal, clear, emit, cntErr;
  logic [31:0] word, nextAddr;
  logic [CNT_W-1:0] cnt, remain;
  assign byteVal = bus.RxVal && bus.RxReady;
  assign cnt = word[CNT_W-1:0];
  assign cntErr = (word >> CNT_W) != 32'd0 || cnt > CNT_W'(MAX_WORDS);
  assign emit = st == ST_DATA && wordVal;
  // Leaving ST_DONE consumes byte 0 of the next header, so that transition must keep the byte.
  assign clear = stNext != st && st != ST_DONE;
  imem_loader_word_pack wordPack (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .byteIn(bus.RxByte),
    .byteVal(byteVal),
    .word(word),
    .wordVal(wordVal)
  );
  always_ff @(posedge clk) begin
    if (reset) st <= ST_ADDR;
    else st <= stNext;
  end
  always_comb begin
    stNext = st;
    unique case (st)
      ST_ADDR: stNext = wordVal ? ST_CNT : ST_ADDR;
      ST_CNT:  stNext = !wordVal ? ST_CNT : cntErr ? ST_ERR : cnt == '0 ? ST_DONE : ST_DATA;
      ST_DATA: stNext = wordVal && remain == CNT_W'(1) ? ST_DONE : ST_DATA;
      ST_DONE: stNext = byteVal ? ST_ADDR : ST_DONE;
      default: stNext = ST_ERR;
    endcase
  end
  always_comb begin
    bus.RxReady = st != ST_ERR;
    bus.CoreReset = st != ST_DONE;
    bus.LoadErr = st == ST_ERR;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.FillVal_FL0 <= 1'b0;
      bus.LoadDone <= 1'b0;
      bus.IntrAddr_FL0 <= '0;
      bus.IntrFill_FL0 <= '0;
      nextAddr <= '0;
      remain <= '0;
    end else begin
      bus.FillVal_FL0 <= emit;
      bus.LoadDone <= stNext == ST_DONE && st != ST_DONE;
      if (st == ST_ADDR && wordVal) nextAddr <= {word[31:2], 2'b00};
      if (st == ST_CNT && wordVal) remain <= cnt;
      if (emit) begin
        bus.IntrAddr_FL0 <= nextAddr;
        bus.IntrFill_FL0 <= word;
        nextAddr <= nextAddr + ADDR_INC;
        remain <= remain - CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: random image streams checked against an address/data expectation queue
module tb_imem_loader;
  localparam int MAX_WORDS = 1024;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic last;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  int doneSeen = 0;
  exp_t expQ[$];
  logic [31:0] img[$];
  imem_loader_if bus();
  imem_loader #(.MAX_WORDS(MAX_WORDS), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!reset && bus.FillVal_FL0) begin
      if (expQ.size() == 0) check("stray_strobe", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = expQ.pop_front();
        check("fill_addr", bus.IntrAddr_FL0, e.a);
        check("fill_data", bus.IntrFill_FL0, e.d);
        check("done_with_last", 32'(bus.LoadDone), 32'(e.last));
        check("corerst_at_strobe", 32'(bus.CoreReset), 32'(!e.last));
      end
    end
    if (!reset && bus.LoadDone) doneSeen++;
  end
  task automatic idle();
    bus.RxVal = 1'b0;
    bus.RxByte = 8'($urandom);
    @(posedge clk);
    #1;
  endtask
  task automatic sendByte(input logic [7:0] b, input bit gappy);
    if (gappy) repeat ($urandom_range(0, 2)) idle();
    bus.RxByte = b;
    bus.RxVal = 1'b1;
    @(posedge clk);
    #1;
    bus.RxVal = 1'b0;
  endtask
  task automatic sendWord(input logic [31:0] w, input bit gappy);
    for (int i = 3; i >= 0; i--) sendByte(w[8*i +: 8], gappy);
  endtask
  task automatic doReset();
    reset = 1'b1;
    bus.RxVal = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  task automatic sendImage(input logic [31:0] base, input bit gappy);
    int n = img.size();
    int d0 = doneSeen;
    for (int k = 0; k < n; k++) expQ.push_back('{a: (base & ~32'd3) + 32'(4 * k), d: img[k], last: k == n - 1});
    sendByte(base[31:24], gappy);
    check("corerst_first_byte", 32'(bus.CoreReset), 32'd1);
    sendByte(base[23:16], gappy);
    sendByte(base[15:8], gappy);
    sendByte(base[7:0], gappy);
    sendWord(32'(n), gappy);
    if (n == 0) begin
      check("n0_done", 32'(bus.LoadDone), 32'd1);
      check("n0_corerst", 32'(bus.CoreReset), 32'd0);
      check("n0_nostrobe", 32'(bus.FillVal_FL0), 32'd0);
    end
    for (int k = 0; k < n; k++) sendWord(img[k], gappy);
    repeat (3) idle();
    check("pending", 32'(expQ.size()), 32'd0);
    check("done_count", 32'(doneSeen - d0), 32'd1);
    check("core_released", 32'(bus.CoreReset), 32'd0);
    check("rx_ready", 32'(bus.RxReady), 32'd1);
    check("no_err", 32'(bus.LoadErr), 32'd0);
  endtask
  task automatic errImage(input logic [31:0] count);
    sendWord(32'h1000, 1'b0);
    sendWord(count, 1'b0);
    check("err_flag", 32'(bus.LoadErr), 32'd1);
    check("err_rxready", 32'(bus.RxReady), 32'd0);
    check("err_corerst", 32'(bus.CoreReset), 32'd1);
    for (int i = 0; i < 8; i++) sendByte(8'($urandom), 1'b0);
    check("err_sticky", 32'(bus.LoadErr), 32'd1);
    doReset();
    check("err_clr_flag", 32'(bus.LoadErr), 32'd0);
    check("err_clr_rxready", 32'(bus.RxReady), 32'd1);
    check("err_clr_corerst", 32'(bus.CoreReset), 32'd1);
  endtask
  initial begin
    bus.RxVal = 1'b0;
    bus.RxByte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_rxready", 32'(bus.RxReady), 32'd1);
    check("rst_corerst", 32'(bus.CoreReset), 32'd1);
    check("rst_fillval", 32'(bus.FillVal_FL0), 32'd0);
    check("rst_done", 32'(bus.LoadDone), 32'd0);
    check("rst_err", 32'(bus.LoadErr), 32'd0);
    check("rst_addr", bus.IntrAddr_FL0, 32'd0);
    check("rst_fill", bus.IntrFill_FL0, 32'd0);
    img = '{32'h20080005, 32'hAC080000};
    sendImage(32'h00000040, 1'b0);
    check("hold_addr", bus.IntrAddr_FL0, 32'h44);
    check("hold_fill", bus.IntrFill_FL0, 32'hAC080000);
    img = '{32'hDEADBEEF};
    sendImage(32'h00000003, 1'b0);
    img = {};
    sendImage(32'h00000100, 1'b0);
    errImage(32'(MAX_WORDS + 1));
    errImage(32'h00010000);
    img = '{32'($urandom), 32'($urandom)};
    sendImage(32'hFFFFFFFC, 1'b1);
    doReset();
    expQ.push_back('{a: 32'h200, d: 32'h11223344, last: 1'b0});
    sendWord(32'h200, 1'b0);
    sendWord(32'd2, 1'b0);
    sendWord(32'h11223344, 1'b0);
    sendByte(8'h55, 1'b0);
    sendByte(8'h66, 1'b0);
    doReset();
    repeat (4) idle();
    check("reset_pending", 32'(expQ.size()), 32'd0);
    check("reset_fillval", 32'(bus.FillVal_FL0), 32'd0);
    img = '{32'hCAFEF00D, 32'h0BADBEEF, 32'h12345678};
    sendImage(32'h00000300, 1'b0);
    img = '{32'h87654321};
    sendImage(32'h00000400, 1'b0);
    for (int t = 0; t < 6; t++) begin
      img = {};
      repeat ($urandom_range(1, 5)) img.push_back(32'($urandom));
      sendImage(32'($urandom), 1'b1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
